// File: rtl/scroll_msg_ctrl_pkg.sv
// Shared display constants and the message-nibble lookup used by the scroll controller.
package disp_pkg;
  localparam int SCAN_W  = 4;
  localparam int CODE_W  = 4;
  localparam int MSG_LEN = 16;
  localparam int MSG_W   = CODE_W * MSG_LEN;

  localparam logic [CODE_W-1:0] BLANK_CODE = 4'hF;

  // Entry 0 is the most significant nibble of the message word.
  function automatic logic [CODE_W-1:0] msg_at(input logic [MSG_W-1:0] msg,
                                               input logic [3:0] idx);
    logic [MSG_W-1:0] sh;
    sh = msg >> {4'd15 - idx, 2'b00};
    return sh[CODE_W-1:0];
  endfunction
endpackage

// File: rtl/scroll_msg_ctrl_btn_debounce.sv
// Button conditioner: two-flop synchronizer, stability counter and a one-cycle
// pulse on every accepted 0->1 transition.
module btn_debounce #(
  parameter int DB_WIDTH = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic rise_o
);
  logic                sync1_q, sync2_q;
  logic                db_q, db_d;
  logic                rise_q, rise_d;
  logic [DB_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= {DB_WIDTH{1'b0}};
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter holds the number of consecutive differing cycles minus one; any agreement restarts it.
  always_comb begin
    db_d   = db_q;
    rise_d = 1'b0;
    cnt_d  = {DB_WIDTH{1'b0}};
    if (sync2_q != db_q) begin
      if (&cnt_q) begin
        db_d   = sync2_q;
        rise_d = sync2_q;
      end else begin
        cnt_d = cnt_q + DB_WIDTH'(1);
      end
    end else begin
      cnt_d = {DB_WIDTH{1'b0}};
    end
  end

  assign rise_o = rise_q;
endmodule

// File: rtl/scroll_msg_ctrl.sv
// Scan-phase generator and scrolling 4-code window over a 16-entry message,
// stepped by a debounced button or an auto timer, applied only at frame boundaries.
module scroll_msg_ctrl
  import disp_pkg::*;
#(
  parameter int               DIV_WIDTH       = 18,
  parameter int               DB_WIDTH        = 16,
  parameter int               FRAMES_PER_STEP = 64,
  parameter logic [MSG_W-1:0] MSG             = 64'h0123456789ABCDEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn,
  input  logic              auto_en,
  output logic [SCAN_W-1:0] count,
  output logic [CODE_W-1:0] char_A3,
  output logic [CODE_W-1:0] char_A2,
  output logic [CODE_W-1:0] char_A1,
  output logic [CODE_W-1:0] char_A0,
  output logic              frame_end
);
  localparam logic [7:0] FPS_LAST = 8'(FRAMES_PER_STEP - 1);

  logic [DIV_WIDTH-1:0] prescaler_q;
  logic [SCAN_W-1:0]    count_q;
  logic                 frame_end_q;
  logic [3:0]           ptr_q, ptr_d;
  logic                 pending_q, pending_d;
  logic [7:0]           frame_cnt_q, frame_cnt_d;
  logic [CODE_W-1:0]    a3_q, a2_q, a1_q, a0_q;
  logic                 ptick_s, boundary_s, btn_rise_s, auto_req_s, step_req_s;

  btn_debounce #(.DB_WIDTH(DB_WIDTH)) u_btn_debounce (
    .clk   (clk),
    .reset (reset),
    .btn_i (btn),
    .rise_o(btn_rise_s)
  );

  assign ptick_s    = &prescaler_q;
  assign boundary_s = ptick_s & (count_q == 4'hF);
  assign step_req_s = btn_rise_s | auto_req_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler_q <= {DIV_WIDTH{1'b0}};
      count_q     <= 4'h0;
      frame_end_q <= 1'b0;
      ptr_q       <= 4'h0;
      pending_q   <= 1'b0;
      frame_cnt_q <= 8'h00;
      a3_q        <= msg_at(MSG, 4'd0);
      a2_q        <= msg_at(MSG, 4'd1);
      a1_q        <= msg_at(MSG, 4'd2);
      a0_q        <= msg_at(MSG, 4'd3);
    end else begin
      prescaler_q <= prescaler_q + DIV_WIDTH'(1);
      count_q     <= count_q + {3'b000, ptick_s};
      frame_end_q <= boundary_s;
      ptr_q       <= ptr_d;
      pending_q   <= pending_d;
      frame_cnt_q <= frame_cnt_d;
      // Window follows ptr one cycle late, so it lands just after count wraps to 0.
      a3_q        <= msg_at(MSG, ptr_q);
      a2_q        <= msg_at(MSG, ptr_q + 4'd1);
      a1_q        <= msg_at(MSG, ptr_q + 4'd2);
      a0_q        <= msg_at(MSG, ptr_q + 4'd3);
    end
  end

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    auto_req_s  = 1'b0;
    if (!auto_en) begin
      frame_cnt_d = 8'h00;
    end else if (boundary_s) begin
      if (frame_cnt_q == FPS_LAST) begin
        frame_cnt_d = 8'h00;
        auto_req_s  = 1'b1;
      end else begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  // Requests within a frame collapse into one step; a request on the boundary itself counts.
  always_comb begin
    pending_d = pending_q;
    ptr_d     = ptr_q;
    if (boundary_s) begin
      pending_d = 1'b0;
      ptr_d     = ptr_q + {3'b000, pending_q | step_req_s};
    end else begin
      pending_d = pending_q | step_req_s;
      ptr_d     = ptr_q;
    end
  end

  assign count     = count_q;
  assign frame_end = frame_end_q;
  assign char_A3   = a3_q;
  assign char_A2   = a2_q;
  assign char_A1   = a1_q;
  assign char_A0   = a0_q;
endmodule

// File: tb/tb_scroll_msg_ctrl.sv
// Randomized and directed bench for scroll_msg_ctrl against a cycle-level behavioural model.
module tb_scroll_msg_ctrl;
  localparam int DIVW  = 2;
  localparam int DBW   = 2;
  localparam int FPS   = 2;
  localparam int PRE   = 1 << DIVW;
  localparam int FRAME = 16 * PRE;
  localparam int DBN   = 1 << DBW;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn = 1'b0;
  logic       auto_en = 1'b0;
  logic [3:0] count, char_A3, char_A2, char_A1, char_A0;
  logic       frame_end;

  int chk_cnt = 0;
  int pass_cnt = 0;

  logic [63:0] msg_v = 64'h0123456789ABCDEF;
  logic [3:0]  nib [16];

  // model state
  int cyc, run, af, ptr, disp;
  bit s1, s2, db, reqb, pend, fe;

  scroll_msg_ctrl #(.DIV_WIDTH(DIVW), .DB_WIDTH(DBW), .FRAMES_PER_STEP(FPS)) dut (
    .clk(clk), .reset(reset), .btn(btn), .auto_en(auto_en),
    .count(count), .char_A3(char_A3), .char_A2(char_A2), .char_A1(char_A1),
    .char_A0(char_A0), .frame_end(frame_end)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    cyc = 0; run = 0; af = 0; ptr = 0; disp = 0;
    s1 = 0; s2 = 0; db = 0; reqb = 0; pend = 0; fe = 0;
  endtask

  task automatic model_step();
    bit bnd, req, reqa;
    if (reset) begin
      model_reset();
    end else begin
      bnd  = (cyc % FRAME) == FRAME - 1;
      req  = reqb;
      reqb = 0;
      if (s2 != db) begin
        run++;
        if (run == DBN) begin db = s2; run = 0; reqb = db; end
      end else run = 0;
      s2 = s1; s1 = btn;
      reqa = 0;
      if (!auto_en) af = 0;
      else if (bnd) begin
        if (af == FPS - 1) begin af = 0; reqa = 1; end
        else af++;
      end
      disp = ptr;
      if (bnd) begin
        if (pend | req | reqa) ptr = (ptr + 1) % 16;
        pend = 0;
      end else pend = pend | req | reqa;
      fe = bnd;
      cyc++;
    end
  endtask

  task automatic check_chars(input string name, input logic [3:0] e3, input logic [3:0] e2,
                             input logic [3:0] e1, input logic [3:0] e0);
    check({name, "_A3"}, char_A3, e3);
    check({name, "_A2"}, char_A2, e2);
    check({name, "_A1"}, char_A1, e1);
    check({name, "_A0"}, char_A0, e0);
  endtask

  task automatic wait_frame_end(input string name);
    int n;
    n = 0;
    while (frame_end !== 1'b1 && n < 4 * FRAME) begin @(negedge clk); n++; end
    check({name, "_frame_end_seen"}, {3'b000, frame_end}, 4'h1);
    check({name, "_count_at_wrap"}, count, 4'h0);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) nib[i] = msg_v[63-4*i -: 4];
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
      #1;
      check("cyc_count", count, 4'((cyc / PRE) % 16));
      check("cyc_frame_end", {3'b000, frame_end}, {3'b000, fe});
      check("cyc_A3", char_A3, nib[disp % 16]);
      check("cyc_A2", char_A2, nib[(disp + 1) % 16]);
      check("cyc_A1", char_A1, nib[(disp + 2) % 16]);
      check("cyc_A0", char_A0, nib[(disp + 3) % 16]);
    end
  end

  initial begin
    int len;
    // reset state
    repeat (3) @(negedge clk);
    check("rst_count", count, 4'h0);
    check("rst_frame_end", {3'b000, frame_end}, 4'h0);
    check_chars("rst", 4'h0, 4'h1, 4'h2, 4'h3);
    reset = 1'b0;

    // free-running scan
    repeat (8) @(negedge clk);
    check("scan_count_after_8", count, 4'h2);
    wait_frame_end("scan");

    // clean press mid-frame
    repeat (16) @(negedge clk);
    btn = 1'b1; repeat (10) @(negedge clk); btn = 1'b0;
    check_chars("press_before", 4'h0, 4'h1, 4'h2, 4'h3);
    wait_frame_end("press");
    @(negedge clk);
    check_chars("press_after", 4'h1, 4'h2, 4'h3, 4'h4);

    // bouncing press then stable hold
    repeat (8) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      btn = ~btn; repeat (2) @(negedge clk);
    end
    btn = 1'b1; repeat (10) @(negedge clk); btn = 1'b0;
    check_chars("bounce_before", 4'h1, 4'h2, 4'h3, 4'h4);
    wait_frame_end("bounce");
    @(negedge clk);
    check_chars("bounce_after", 4'h2, 4'h3, 4'h4, 4'h5);

    // auto advance and wrap
    auto_en = 1'b1;
    do_reset();
    repeat (30 * FRAME + 2) @(negedge clk);
    check_chars("auto_15", 4'hF, 4'h0, 4'h1, 4'h2);
    repeat (2 * FRAME) @(negedge clk);
    check_chars("auto_wrap", 4'h0, 4'h1, 4'h2, 4'h3);

    // button and auto request in the same frame
    do_reset();
    repeat (70) @(negedge clk);
    btn = 1'b1; repeat (10) @(negedge clk); btn = 1'b0;
    repeat (50) @(negedge clk);
    check_chars("merge", 4'h1, 4'h2, 4'h3, 4'h4);
    auto_en = 1'b0;
    repeat (FRAME) @(negedge clk);
    check_chars("merge_hold", 4'h1, 4'h2, 4'h3, 4'h4);

    // reset with a step pending at ptr=7
    auto_en = 1'b1;
    do_reset();
    repeat (14 * FRAME + 4) @(negedge clk);
    check_chars("pre_rst_ptr7", 4'h7, 4'h8, 4'h9, 4'hA);
    auto_en = 1'b0;
    btn = 1'b1; repeat (10) @(negedge clk);
    reset = 1'b1; btn = 1'b0;
    #1;
    check("midrst_count", count, 4'h0);
    check("midrst_frame_end", {3'b000, frame_end}, 4'h0);
    check_chars("midrst", 4'h0, 4'h1, 4'h2, 4'h3);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2 * FRAME + 2) @(negedge clk);
    check_chars("midrst_after", 4'h0, 4'h1, 4'h2, 4'h3);

    // randomized button/auto/reset activity
    for (int s = 0; s < 300; s++) begin
      btn = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 59) == 0) reset = 1'b1;
      len = $urandom_range(1, 12);
      repeat (len) @(negedge clk);
      reset = 1'b0;
    end
    btn = 1'b0; auto_en = 1'b0;
    repeat (3 * FRAME) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
